// File: rtl/vblank_arbiter.sv
// vblank_arbiter
//   Round-robin arbiter granting N_REQ requesters access to a shared
//   sprite-memory write port, only while the VGA timing is in vertical
//   blanking. A grant ends when the owner drops its request, after
//   MAX_BURST cycles, or when blanking ends (flagged by overrun_o).
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   vblank_i          high outside the visible area
//   req_i / wr_en_i   per-requester request level and write strobe
//   wr_addr_i         packed addresses, requester k at [k*AW +: AW]
//   wr_data_i         packed data, requester k at [k*DW +: DW]
//   grant_o           registered one-hot (or zero) grant
//   mem_we_o/addr/data  registered shared write port
//   frame_cnt_o       count of vblank rising edges (wraps)
//   overrun_o         one-cycle pulse when blanking ends mid-grant
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | visible area or just reset; no grant, wait for vblank
// S_ARB   | in blanking with no owner; pick next requester round-robin
// S_GRANT | one requester owns the write port; burst counter running

module vblank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vblank_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    wr_en_i,
    input  logic [N_REQ*AW-1:0] wr_addr_i,
    input  logic [N_REQ*DW-1:0] wr_data_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_data_o,
    output logic [15:0]         frame_cnt_o,
    output logic                overrun_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [BW-1:0]      r_burst;
    logic [N_REQ-1:0]   r_grant;
    logic               r_overrun;
    logic               r_vblank;
    logic [15:0]        r_frame_cnt;
    logic               r_mem_we;
    logic [AW-1:0]      r_mem_addr;
    logic [DW-1:0]      r_mem_data;

    state_t             w_state_nxt;
    logic [IW-1:0]      w_ptr_nxt;
    logic [IW-1:0]      w_owner_nxt;
    logic [BW-1:0]      w_burst_nxt;
    logic [N_REQ-1:0]   w_grant_nxt;
    logic               w_overrun_nxt;
    logic               w_found;
    logic [IW-1:0]      w_sel;
    int                 w_best_dist;
    int                 w_dist;

    // Round-robin pick: the requesting index with the smallest distance
    // from (ptr+1), counting upward with wrap.
    always_comb begin
        w_found     = 1'b0;
        w_sel       = '0;
        w_best_dist = N_REQ;
        w_dist      = 0;
        for (int c = 0; c < N_REQ; c++) begin
            w_dist = (c - int'(r_ptr) - 1 + 2 * N_REQ) % N_REQ;
            if (req_i[c] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_sel       = IW'(c);
                w_found     = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_owner_nxt   = r_owner;
        w_burst_nxt   = r_burst;
        w_grant_nxt   = '0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (vblank_i) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!vblank_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_sel;
                    w_grant_nxt = N_REQ'(1) << w_sel;
                    w_burst_nxt = '0;
                end
            end
            S_GRANT: begin
                // End of blanking takes priority over a request drop.
                if (!vblank_i) begin
                    w_state_nxt   = S_IDLE;
                    w_ptr_nxt     = r_owner;
                    w_overrun_nxt = 1'b1;
                end else if (!req_i[r_owner] || (r_burst == BURST_LAST)) begin
                    w_state_nxt = S_ARB;
                    w_ptr_nxt   = r_owner;
                end else begin
                    w_grant_nxt = r_grant;
                    w_burst_nxt = r_burst + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= IW'(N_REQ - 1);
            r_owner   <= '0;
            r_burst   <= '0;
            r_grant   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_burst   <= w_burst_nxt;
            r_grant   <= w_grant_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Write port: the owner's bus passes through one register stage;
    // address/data hold their last value while nobody owns the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (|r_grant) begin
            r_mem_we   <= r_grant[r_owner] & wr_en_i[r_owner];
            r_mem_addr <= wr_addr_i[int'(r_owner) * AW +: AW];
            r_mem_data <= wr_data_i[int'(r_owner) * DW +: DW];
        end else begin
            r_mem_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblank    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vblank <= vblank_i;
            if (vblank_i && !r_vblank) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign grant_o     = r_grant;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign frame_cnt_o = r_frame_cnt;
    assign overrun_o   = r_overrun;

endmodule

// File: doc/vblank_arbiter.md
VBLANK_ARBITER -- requirements
Module: vblank_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing the sprite-memory write port (2..8).
REQ-002 Parameter AW, 12, sprite-memory address width.
REQ-003 Parameter DW, 16, sprite-memory data width.
REQ-004 Parameter MAX_BURST, 64, maximum consecutive granted cycles before forced release (>=2).
REQ-005 Port clk  in  1  single system clock; all logic rising-edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port vblank_i  in  1  high while the VGA timing driver is outside the visible area (not disp).
REQ-008 Port req_i  in  N_REQ  per-requester access request, level.
REQ-009 Port wr_en_i  in  N_REQ  per-requester write strobe.
REQ-010 Port wr_addr_i  in  N_REQ*AW  packed addresses, requester k at [k*AW +: AW].
REQ-011 Port wr_data_i  in  N_REQ*DW  packed data, requester k at [k*DW +: DW].
REQ-012 Port grant_o  out  N_REQ  one-hot or zero grant, registered.
REQ-013 Port mem_we_o / mem_addr_o / mem_data_o  out  1 / AW / DW  shared write port, registered.
REQ-014 Port frame_cnt_o  out  16  count of vblank rising edges, registered.
REQ-015 Port overrun_o  out  1  one-cycle pulse when a grant is revoked by vblank falling.

Function
REQ-016 FSM states IDLE, ARB, GRANT; no other states reachable.
REQ-017 IDLE: grant_o=0; go ARB when vblank_i=1.
REQ-018 ARB: if vblank_i=0 go IDLE; else if req_i!=0 select first requester with req=1 searching from (ptr+1) mod N_REQ upward with wrap, assert its grant_o bit next cycle, enter GRANT, clear burst counter; else stay ARB.
REQ-019 GRANT with owner g: stay while req_i[g]=1, vblank_i=1 and burst counter < MAX_BURST-1; counter increments each GRANT cycle.
REQ-020 GRANT exit on req_i[g]=0 or counter reaching MAX_BURST-1: grant_o cleared next cycle, ptr<=g, go ARB; at least one zero-grant cycle between owners.
REQ-021 GRANT exit on vblank_i=0: grant_o cleared next cycle, overrun_o=1 for exactly that cycle, ptr<=g, go IDLE.
REQ-022 Simultaneous req drop and vblank fall: vblank rule (REQ-021) wins, overrun_o asserted.
REQ-023 Write path: one register stage; mem_we_o = grant_o[g] & wr_en_i[g] sampled this cycle, mem_addr_o/mem_data_o = owner's bus; when no grant, mem_we_o=0 and addr/data hold last value.
REQ-024 Writes from non-granted requesters ignored; wr_en_i in cycle grant is first visible is accepted.
REQ-025 frame_cnt_o increments by 1 on each 0->1 transition of registered vblank_i; wraps 0xFFFF->0x0000.
REQ-026 Round-robin fairness: continuously requesting requester granted within N_REQ grant intervals.

Reset
REQ-027 rst_n=0 asynchronously forces: state IDLE, grant_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, frame_cnt_o=0, overrun_o=0, ptr=N_REQ-1 (so requester 0 wins first), burst counter=0, vblank edge register=0.
REQ-028 Reset mid-grant drops grant immediately without overrun pulse; after rst_n rise, first arbitration no earlier than second clk edge.

Verification
REQ-029 Reset, vblank_i=1, req_i=4'b1111 held -> grants 0,1,2,3,0 in order, each lasting MAX_BURST cycles, one zero-grant cycle between.
REQ-030 vblank_i=0, req_i=4'b0010 -> grant_o stays 0, mem_we_o stays 0; vblank_i rise -> grant_o=4'b0010 two cycles after.
REQ-031 Owner 2 granted, wr_en_i[2]=1, addr 0x123, data 0xBEEF -> next cycle mem_we_o=1, mem_addr_o=0x123, mem_data_o=0xBEEF; wr_en_i[1]=1 concurrently -> no effect.
REQ-032 Owner 1 granted, vblank_i falls -> next cycle grant_o=0, overrun_o=1 for 1 cycle; next vblank with req_i=4'b1111 -> requester 2 first.
REQ-033 Preload frame_cnt to 0xFFFF via 65535 vblank pulses (or force) -> next pulse frame_cnt_o=0x0000.
REQ-034 rst_n low asynchronously mid-burst -> grant_o, mem_we_o, overrun_o 0 without waiting for clk edge.
